// File: rtl/gmii_pkg.sv
// gmii_pkg: GMII framing constants and framer state encoding shared by TX framer and RX checker
package gmii_pkg;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} tx_state_t;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: one-byte update of the reflected IEEE 802.3 CRC32, LSB of data first
module crc32_d8
   import gmii_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);
   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 8; i++)
         crc_out = (crc_out >> 1) ^ (CRC_POLY & {32{crc_out[0] ^ data[i]}});
   end
endmodule

// File: rtl/gig_eth_tx_framer.sv
// gig_eth_tx_framer: byte stream to GMII frame with preamble/SFD, zero padding, FCS and IFG
module gig_eth_tx_framer
   import gmii_pkg::*;
#(
   parameter int MIN_LEN = 60,
   parameter int IFG_LEN = 12
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       frame_done,
   output logic       underrun
);
   tx_state_t   r_state;
   logic [2:0]  r_pre;
   logic [1:0]  r_fidx;
   logic [7:0]  r_ifg;
   logic [15:0] r_cnt;
   logic [31:0] r_crc;
   logic        r_done_pend;
   logic [7:0]  w_byte;
   logic [15:0] w_cnt_nx;
   logic [31:0] w_crc;
   logic [31:0] w_fcs;
   logic        w_short;

   assign s_ready  = (r_state == DATA);
   assign w_byte   = (r_state == PAD) ? 8'h00 : s_data;
   assign w_cnt_nx = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
   assign w_short  = {16'd0, w_cnt_nx} < 32'(MIN_LEN);
   assign w_fcs    = ~r_crc;

   crc32_d8 u_crc (.crc_in(r_crc), .data(w_byte), .crc_out(w_crc));

   // frame_done trails the last FCS byte by one cycle, hence the pending stage
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_pre       <= '0;
         r_fidx      <= '0;
         r_ifg       <= '0;
         r_cnt       <= '0;
         r_crc       <= CRC_INIT;
         r_done_pend <= 1'b0;
         gmii_txd    <= '0;
         gmii_tx_en  <= 1'b0;
         gmii_tx_er  <= 1'b0;
         frame_done  <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         gmii_tx_er  <= 1'b0;
         underrun    <= 1'b0;
         frame_done  <= r_done_pend;
         r_done_pend <= 1'b0;
         case (r_state)
            IDLE: begin
               gmii_tx_en <= s_valid;
               gmii_txd   <= s_valid ? PREAMBLE_BYTE : 8'h00;
               if (s_valid) begin
                  r_state <= PREAMBLE;
                  r_pre   <= 3'd1;
                  r_cnt   <= '0;
                  r_crc   <= CRC_INIT;
               end
            end
            PREAMBLE: begin
               gmii_tx_en <= 1'b1;
               gmii_txd   <= (r_pre == 3'd7) ? SFD_BYTE : PREAMBLE_BYTE;
               r_pre      <= r_pre + 3'd1;
               if (r_pre == 3'd7) r_state <= DATA;
            end
            DATA: begin
               gmii_tx_en <= 1'b1;
               gmii_txd   <= s_valid ? s_data : 8'h00;
               gmii_tx_er <= !s_valid;
               underrun   <= !s_valid;
               if (s_valid) begin
                  r_crc <= w_crc;
                  r_cnt <= w_cnt_nx;
                  if (s_last) r_state <= w_short ? PAD : FCS;
               end else begin
                  r_state <= IFG;
                  r_ifg   <= '0;
               end
            end
            PAD: begin
               gmii_tx_en <= 1'b1;
               gmii_txd   <= 8'h00;
               r_crc      <= w_crc;
               r_cnt      <= w_cnt_nx;
               if (!w_short) r_state <= FCS;
            end
            FCS: begin
               gmii_tx_en <= 1'b1;
               gmii_txd   <= w_fcs[{r_fidx, 3'b000} +: 8];
               r_fidx     <= r_fidx + 2'd1;
               if (r_fidx == 2'd3) begin
                  r_state     <= IFG;
                  r_ifg       <= '0;
                  r_done_pend <= 1'b1;
               end
            end
            IFG: begin
               gmii_tx_en <= 1'b0;
               gmii_txd   <= 8'h00;
               if (r_ifg == 8'(IFG_LEN)) r_state <= IDLE;
               else r_ifg <= r_ifg + 8'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gig_eth_tx_framer.sv
// tb_gig_eth_tx_framer: directed checks of framing, padding, FCS, IFG, underrun and reset
module tb_gig_eth_tx_framer;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] s_data = '0;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       sel = 1'b0;
   logic       rdy0, rdy1, en0, en1, er0, er1, dn0, dn1, ur0, ur1;
   logic [7:0] txd0, txd1;
   logic       w_ready, w_en, w_er, w_done, w_ur;
   logic [7:0] w_txd;
   int         compared = 0, mism = 0;
   int         cyc = 0, en_cnt = 0, er_cnt = 0, done_cnt = 0;
   int         last_en_cyc = 0, first_en_cyc = 0, done_cyc = 0, low_run = 0, gap_last = 0;
   logic [7:0] rx_q[$];
   logic [7:0] pay[$];

   always #4 clock = ~clock;

   gig_eth_tx_framer #(.MIN_LEN(0), .IFG_LEN(12)) u_dut0 (
      .clock(clock), .reset(reset), .s_data(s_data), .s_valid(s_valid && !sel), .s_last(s_last),
      .s_ready(rdy0), .gmii_txd(txd0), .gmii_tx_en(en0), .gmii_tx_er(er0),
      .frame_done(dn0), .underrun(ur0));

   gig_eth_tx_framer #(.MIN_LEN(60), .IFG_LEN(12)) u_dut1 (
      .clock(clock), .reset(reset), .s_data(s_data), .s_valid(s_valid && sel), .s_last(s_last),
      .s_ready(rdy1), .gmii_txd(txd1), .gmii_tx_en(en1), .gmii_tx_er(er1),
      .frame_done(dn1), .underrun(ur1));

   assign w_ready = sel ? rdy1 : rdy0;
   assign w_txd   = sel ? txd1 : txd0;
   assign w_en    = sel ? en1 : en0;
   assign w_er    = sel ? er1 : er0;
   assign w_done  = sel ? dn1 : dn0;
   assign w_ur    = sel ? ur1 : ur0;

   always @(negedge clock) begin
      cyc++;
      if (w_en) begin
         rx_q.push_back(w_txd);
         en_cnt++;
         last_en_cyc = cyc;
         if (low_run > 0) begin
            gap_last = low_run;
            first_en_cyc = cyc;
         end
         low_run = 0;
      end else low_run++;
      if (w_er) er_cnt++;
      if (w_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_model(input logic [7:0] q[$]);
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (q[k]) begin
         c ^= {24'd0, q[k]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   task automatic send(input int stop_at);
      int idx = 0, guard = 0;
      logic r;
      s_valid = 1'b1;
      while (idx < pay.size() && idx != stop_at && guard < 4000) begin
         s_data = pay[idx];
         s_last = (idx == pay.size() - 1);
         @(negedge clock);
         r = w_ready;
         @(posedge clock);
         #1;
         if (r) idx++;
         guard++;
      end
      s_valid = 1'b0;
      s_last = 1'b0;
      if (guard >= 4000) chk("send_timeout", guard, 0);
   endtask

   task automatic run_frame(input string tag, input int min_len, input int gap, output logic [31:0] fcs_got);
      int base, guard, bad, n, start;
      logic [7:0] exp[$];
      logic [31:0] c;
      repeat (gap) begin
         @(posedge clock);
         #1;
      end
      rx_q.delete();
      base = done_cnt;
      start = cyc;
      send(-1);
      guard = 0;
      while (done_cnt == base && guard < 4000) begin
         @(negedge clock);
         guard++;
      end
      chk({tag, "_done"}, done_cnt - base, 1);
      exp = pay;
      while (exp.size() < min_len) exp.push_back(8'h00);
      c = crc_model(exp);
      n = rx_q.size();
      chk({tag, "_len"}, n, 12 + exp.size());
      bad = 0;
      for (int i = 0; i < 8; i++) if (i >= n || rx_q[i] !== ((i == 7) ? 8'hD5 : 8'h55)) bad++;
      for (int i = 0; i < exp.size(); i++) if (8 + i >= n || rx_q[8 + i] !== exp[i]) bad++;
      chk({tag, "_bytes"}, bad, 0);
      fcs_got = (n >= 4) ? {rx_q[n-1], rx_q[n-2], rx_q[n-3], rx_q[n-4]} : 32'd0;
      chk({tag, "_fcs"}, fcs_got, ~c);
      chk({tag, "_done_pos"}, done_cyc - last_en_cyc, 1);
      chk({tag, "_sop"}, first_en_cyc - start, 2);
   endtask

   initial begin
      logic [31:0] fcs;
      int base, guard, bad, en_base, er_base;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_dut0", {en0, er0, txd0, rdy0, dn0, ur0}, 0);
      chk("rst_dut1", {en1, er1, txd1, rdy1, dn1, ur1}, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      er_base = er_cnt;

      sel = 1'b0;
      pay.delete();
      for (int i = 0; i < 9; i++) pay.push_back(8'(49 + i));
      run_frame("check9", 0, 2, fcs);
      chk("check9_const", fcs, 32'hCBF43926);

      sel = 1'b1;
      pay.delete();
      for (int i = 0; i < 14; i++) pay.push_back(8'(8'hA0 + i));
      en_base = en_cnt;
      run_frame("pad14", 60, 15, fcs);
      chk("pad14_en_cycles", en_cnt - en_base, 72);

      pay.delete();
      for (int i = 0; i < 64; i++) pay.push_back(8'(i * 7 + 3));
      repeat (15) begin
         @(posedge clock);
         #1;
      end
      base = done_cnt;
      send(-1);
      send(-1);
      guard = 0;
      while (done_cnt - base < 2 && guard < 4000) begin
         @(negedge clock);
         guard++;
      end
      chk("b2b_done", done_cnt - base, 2);
      chk("b2b_gap", gap_last, 13);
      chk("er_clean", er_cnt - er_base, 0);

      repeat (15) begin
         @(posedge clock);
         #1;
      end
      base = done_cnt;
      er_base = er_cnt;
      send(20);
      @(negedge clock);
      chk("ur_byte20", {w_en, w_er, w_txd}, {1'b1, 1'b0, pay[19]});
      @(negedge clock);
      chk("ur_cycle", {w_en, w_er, w_txd, w_ur}, {1'b1, 1'b1, 8'h00, 1'b1});
      bad = 0;
      repeat (12) begin
         @(negedge clock);
         if (w_en || w_er || w_ur) bad++;
      end
      chk("ur_ifg", bad, 0);
      repeat (10) @(negedge clock);
      chk("ur_no_done", done_cnt - base, 0);
      chk("ur_er_once", er_cnt - er_base, 1);

      @(posedge clock);
      #1;
      er_base = er_cnt;
      send(29);
      s_data = pay[29];
      s_valid = 1'b1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      s_valid = 1'b0;
      @(negedge clock);
      chk("rst_mid", {w_en, w_er, w_ready, w_txd, w_ur, w_done}, 0);
      pay.delete();
      for (int i = 0; i < 40; i++) pay.push_back(8'(255 - i * 3));
      run_frame("after_rst", 60, 1, fcs);
      chk("rst_no_er", er_cnt - er_base, 0);

      for (int f = 0; f < 3; f++) begin
         int len;
         len = $urandom_range(1, 1518);
         pay.delete();
         for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
         run_frame($sformatf("rand%0d", f), 60, $urandom_range(15, 25), fcs);
      end
      chk("rand_no_er", er_cnt - er_base, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end
endmodule

// File: doc/gig_eth_tx_framer.md
GIG_ETH_TX_FRAMER -- requirements
Module: gig_eth_tx_framer

Interface
REQ-001 Parameter MIN_LEN, default 60, minimum payload+pad byte count before FCS; 0 disables padding.
REQ-002 Parameter IFG_LEN, default 12, minimum idle cycles (tx_en low) between frames; legal range 1..255.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clock  input  1  GMII 125 MHz clock (PCS/PMA sgmii_clk); all logic on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 s_data  input  8  payload byte (destination MAC first, no preamble/FCS).
REQ-007 s_valid  input  1  s_data/s_last valid.
REQ-008 s_last  input  1  current byte is last payload byte.
REQ-009 s_ready  output  1  byte accepted on edge where s_valid && s_ready.
REQ-010 gmii_txd  output  8  GMII transmit data, registered.
REQ-011 gmii_tx_en  output  1  GMII transmit enable, registered.
REQ-012 gmii_tx_er  output  1  GMII transmit error, registered.
REQ-013 frame_done  output  1  one-cycle pulse, cycle after last FCS byte leaves gmii_txd.
REQ-014 underrun  output  1  one-cycle pulse, coincident with the gmii_tx_er cycle.

Function
REQ-015 FSM states SHALL be IDLE, PREAMBLE, DATA, PAD, FCS, IFG; s_ready = (state == DATA), decoded from state register only.
REQ-016 IDLE: gmii_tx_en=0, gmii_tx_er=0, gmii_txd=0x00; s_valid=1 sampled -> PREAMBLE (no byte consumed).
REQ-017 PREAMBLE: wire carries 7 cycles 0x55 then 1 cycle 0xD5 with tx_en=1; first preamble byte on wire the cycle after s_valid was sampled in IDLE; then DATA.
REQ-018 DATA: byte accepted at edge k appears on gmii_txd at k+1 with tx_en=1; one byte per cycle, no bubbles.
REQ-019 DATA with s_last accepted: -> PAD if byte count < MIN_LEN, else -> FCS.
REQ-020 PAD: emit 0x00 bytes until payload+pad count == MIN_LEN, then FCS.
REQ-021 Byte counter 16 bits, saturating at 0xFFFF; cleared on entry to PREAMBLE.
REQ-022 CRC: IEEE 802.3 reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated over every payload and pad byte, reinitialised on entry to PREAMBLE.
REQ-023 FCS: emit ~CRC over 4 cycles, bits [7:0] first through [31:24], tx_en=1; then IFG.
REQ-024 IFG: tx_en=0, txd=0x00 for exactly IFG_LEN cycles, then IDLE; s_valid ignored until IDLE.
REQ-025 Underrun: DATA with s_valid=0 -> next cycle txd=0x00, tx_en=1, tx_er=1, underrun=1 for one cycle, then IFG; no FCS; frame_done not asserted.
REQ-026 gmii_tx_er SHALL be 0 in every cycle except the underrun cycle.
REQ-027 Zero-length frame impossible: first DATA byte is always consumed or underruns.
REQ-028 Back-to-back frames: minimum spacing between last FCS byte and next preamble byte is IFG_LEN idle cycles plus one IDLE cycle.

Reset
REQ-029 On reset sampled high: next cycle state=IDLE, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, s_ready=0, frame_done=0, underrun=0, counters=0, CRC=0xFFFFFFFF.
REQ-030 Reset mid-frame SHALL truncate immediately without tx_er, FCS or IFG; first frame after reset may start in the cycle after reset deasserts.

Structure
REQ-031 Shared package gmii_pkg SHALL hold PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY 0xEDB88320, CRC_INIT 0xFFFFFFFF, and the framer state enum.
REQ-032 Sub-module crc32_d8 (combinational: crc_in[31:0], data[7:0] -> crc_out[31:0]) SHALL implement one byte of CRC update; reused by the RX checker.

Verification
REQ-033 MIN_LEN=0, payload ASCII "123456789" -> wire 55x7, D5, 31..39, FCS 26 39 F4 CB, frame_done one cycle later.
REQ-034 MIN_LEN=60, 14-byte payload -> 46 pad bytes 0x00, tx_en high for exactly 8+60+4=72 cycles, FCS matches software model.
REQ-035 Two 64-byte frames, s_valid continuously 1 -> exactly IFG_LEN=12 tx_en-low cycles plus 1 IDLE cycle between frames.
REQ-036 s_valid dropped after 20 accepted bytes -> one cycle tx_en=1, tx_er=1, txd=00, underrun=1; then 12 idle cycles; no FCS; frame_done=0.
REQ-037 reset asserted during 30th payload byte -> next cycle tx_en=0, tx_er=0, s_ready=0; new frame after reset transmits correct preamble and FCS.
REQ-038 Random payload 1..1518 bytes, random s_valid gaps only in IDLE -> every frame's FCS equals reference CRC32, tx_er never asserted.
